// File: rtl/tensor_core_pkg.sv
// tensor_core_pkg: shared types and constants for the tensor core operand loader
package tensor_core_pkg;

    localparam int DATA_WIDTH          = 8;
    localparam int ELEMENTS_PER_MATRIX = 9;
    localparam int QUAD_LANES          = 4;

    typedef logic [2:0] quad_addr_t;
    typedef logic signed [DATA_WIDTH-1:0] element_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } loader_state_t;

endpackage

// File: rtl/tensor_core_quad_packer.sv
// tensor_core_quad_packer: lane buffer and lane counter that assemble one quad of elements
module tensor_core_quad_packer #(
    parameter int DATA_WIDTH = tensor_core_pkg::DATA_WIDTH
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic                         push,
    input  logic                         clear,
    input  logic [2:0]                   lanes_needed,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic signed [DATA_WIDTH-1:0] lanes [tensor_core_pkg::QUAD_LANES],
    output logic                         full
);
    import tensor_core_pkg::*;

    logic [2:0]                   count_q, count_d;
    logic signed [DATA_WIDTH-1:0] lanes_q [QUAD_LANES];
    logic signed [DATA_WIDTH-1:0] lanes_d [QUAD_LANES];

    // Clear zeroes every lane so unused lanes of a short quad read as 0; push fills the next lane
    always_comb begin
        lanes_d = lanes_q;
        count_d = count_q;
        if (clear) begin
            lanes_d = '{default: '0};
            count_d = '0;
        end else if (push) begin
            lanes_d[count_q[1:0]] = data_in;
            count_d               = count_q + 3'd1;
        end
    end

    // Lane storage and fill count
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            lanes_q <= '{default: '0};
            count_q <= '0;
        end else begin
            lanes_q <= lanes_d;
            count_q <= count_d;
        end
    end

    assign lanes = lanes_q;
    // Asserted on the push that completes the quad, so the caller can move to WRITE on that edge
    assign full  = push && (count_q + 3'd1 == lanes_needed);

endmodule

// File: rtl/tensor_core_quad_loader.sv
// tensor_core_quad_loader: packs a signed byte stream into quad writes for the tensor core register file.
// Optional QUAD_LOADER_PARTIAL_START_EN adds start_quad_in so a load can begin at a later quad.
module tensor_core_quad_loader #(
    parameter int DATA_WIDTH   = tensor_core_pkg::DATA_WIDTH,
    parameter int NUM_MATRICES = 2
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic                         start_in,
`ifdef QUAD_LOADER_PARTIAL_START_EN
    input  logic [2:0]                   start_quad_in,
`endif
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         data_valid_in,
    output logic                         data_ready_out,
    output logic                         quad_write_enable_out,
    output logic [2:0]                   quad_write_register_address_out,
    output logic signed [DATA_WIDTH-1:0] quad_write_data_out [tensor_core_pkg::QUAD_LANES],
    output logic                         busy_out,
    output logic                         done_out
);
    import tensor_core_pkg::*;

    localparam int ELEMENTS   = ELEMENTS_PER_MATRIX * NUM_MATRICES;
    localparam int QUADS      = (ELEMENTS + QUAD_LANES - 1) / QUAD_LANES;
    localparam int LAST_LANES = ELEMENTS - QUAD_LANES * (QUADS - 1);
    localparam quad_addr_t LAST_Q = quad_addr_t'(QUADS - 1);

    loader_state_t state_q, state_d;
    quad_addr_t    addr_q, addr_d, start_addr;
    logic          ready_q, ready_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
    logic          clear, push, quad_full;
    logic [2:0]    lanes_needed;
    logic signed [DATA_WIDTH-1:0] lanes  [QUAD_LANES];
    logic signed [DATA_WIDTH-1:0] hold_q [QUAD_LANES];
    logic signed [DATA_WIDTH-1:0] hold_d [QUAD_LANES];

`ifdef QUAD_LOADER_PARTIAL_START_EN
    assign start_addr = (start_quad_in >= LAST_Q) ? LAST_Q : start_quad_in;
`else
    assign start_addr = '0;
`endif

    assign push         = data_valid_in & ready_q;
    assign lanes_needed = (addr_q == LAST_Q) ? 3'(LAST_LANES) : 3'(QUAD_LANES);

    tensor_core_quad_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
        .clock_in    (clock_in),
        .reset_in    (reset_in),
        .push        (push),
        .clear       (clear),
        .lanes_needed(lanes_needed),
        .data_in     (data_in),
        .lanes       (lanes),
        .full        (quad_full)
    );

    // Load sequencing; registered outputs are derived from the state being entered
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        clear   = 1'b0;
        case (state_q)
            IDLE: if (start_in) begin
                state_d = FILL;
                addr_d  = start_addr;
                clear   = 1'b1;
            end
            FILL: if (quad_full) state_d = WRITE;
            WRITE: if (addr_q == LAST_Q) begin
                state_d = DONE;
            end else begin
                state_d = FILL;
                addr_d  = addr_q + 3'd1;
                clear   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        ready_d = state_d == FILL;
        we_d    = state_d == WRITE;
        busy_d  = state_d != IDLE;
        done_d  = state_d == DONE;
    end

    // Data bus shows the packer lanes during the strobe and keeps the last written quad afterwards
    always_comb begin
        for (int i = 0; i < QUAD_LANES; i++) begin
            quad_write_data_out[i] = we_q ? lanes[i] : hold_q[i];
            hold_d[i]              = quad_write_data_out[i];
        end
    end

    // State, address and output registers
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= IDLE;
            addr_q  <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hold_q  <= hold_d;
        end
    end

    assign data_ready_out                  = ready_q;
    assign quad_write_enable_out           = we_q;
    assign quad_write_register_address_out = addr_q;
    assign busy_out                        = busy_q;
    assign done_out                        = done_q;

endmodule

// File: tb/tb_tensor_core_quad_loader.sv
// tb_tensor_core_quad_loader: directed/randomized bench for the quad loader with a stream-level reference model
module tb_tensor_core_quad_loader;

    typedef struct {
        logic [2:0]        a;
        logic signed [7:0] d [4];
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start [2];
    logic [2:0] start_quad = '0;
    logic signed [7:0] data_in = '0;
    logic valid = 1'b0;
    logic rdy [2], we [2], busy [2], done [2];
    logic [2:0] addr [2];
    logic signed [7:0] qd [2][4];
    logic signed [7:0] sp [4] = '{8'h80, 8'h7f, 8'hff, 8'h00};

    int n_cmp = 0, n_fail = 0, cyc = 0;
    int last_hs [2];
    int done_cnt [2];
    wr_t wq [$];
    logic signed [7:0] acc [$];
    logic signed [7:0] stim [$];

    tensor_core_quad_loader #(.NUM_MATRICES(2)) dut2 (
        .clock_in(clk), .reset_in(rst_n), .start_in(start[0]),
`ifdef QUAD_LOADER_PARTIAL_START_EN
        .start_quad_in(start_quad),
`endif
        .data_in(data_in), .data_valid_in(valid), .data_ready_out(rdy[0]),
        .quad_write_enable_out(we[0]), .quad_write_register_address_out(addr[0]),
        .quad_write_data_out(qd[0]), .busy_out(busy[0]), .done_out(done[0])
    );

    tensor_core_quad_loader #(.NUM_MATRICES(1)) dut1 (
        .clock_in(clk), .reset_in(rst_n), .start_in(start[1]),
`ifdef QUAD_LOADER_PARTIAL_START_EN
        .start_quad_in(start_quad),
`endif
        .data_in(data_in), .data_valid_in(valid), .data_ready_out(rdy[1]),
        .quad_write_enable_out(we[1]), .quad_write_register_address_out(addr[1]),
        .quad_write_data_out(qd[1]), .busy_out(busy[1]), .done_out(done[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Observe handshakes, write strobes and done pulses away from the active edge
    always @(negedge clk) begin
        wr_t w;
        for (int d = 0; d < 2; d++) begin
            if (we[d] === 1'b1) begin
                chk("ready_low_in_write", rdy[d], 0);
                chk("strobe_latency", cyc, last_hs[d] + 1);
                w.a = addr[d];
                w.d = qd[d];
                wq.push_back(w);
            end
            if (valid && rdy[d] === 1'b1) begin
                acc.push_back(data_in);
                last_hs[d] = cyc;
            end
            if (done[d] === 1'b1) done_cnt[d]++;
        end
    end

    task automatic check_zero(input int d);
        chk("rst_ready", rdy[d], 0);
        chk("rst_we", we[d], 0);
        chk("rst_busy", busy[d], 0);
        chk("rst_done", done[d], 0);
        chk("rst_addr", addr[d], 0);
        for (int i = 0; i < 4; i++) chk("rst_lane", qd[d][i], 0);
    endtask

    task automatic begin_load(input int d, input int sq);
        start_quad = 3'(sq);
        @(posedge clk); #1 start[d] = 1'b1;
        @(posedge clk); #1 start[d] = 1'b0;
        chk("busy_after_start", busy[d], 1);
    endtask

    task automatic stream(input int d, input int n, input bit toggle, input int pulse_idx);
        int idx = 0, g = 0;
        bit hs;
        while (idx < n && g < 4000) begin
            data_in  = stim[idx];
            valid    = toggle ? ((g % 2) == 0) : 1'b1;
            start[d] = (idx == pulse_idx);
            @(negedge clk);
            hs = valid && rdy[d];
            @(posedge clk); #1;
            if (hs) idx++;
            g++;
        end
        valid    = 1'b0;
        start[d] = 1'b0;
        chk("stream_complete", idx, n);
    endtask

    // mode 0: 1,2,3..; mode 1: extremes then random; mode 2: random
    task automatic fill_stim(input int n, input int mode);
        stim.delete();
        for (int i = 0; i < n; i++)
            stim.push_back(mode == 0 ? 8'(i + 1) : (mode == 1 && i < 4) ? sp[i] : 8'($urandom));
    endtask

    task automatic run_load(input int d, input int sq, input int mode, input bit toggle, input int pulse_idx);
        int elems, quads, sqe, n, g, k;
        elems = (d == 0) ? 18 : 9;
        quads = (elems + 3) / 4;
        sqe   = (sq >= quads) ? quads - 1 : sq;
        n     = elems - 4 * sqe;
        fill_stim(n, mode);
        wq.delete();
        acc.delete();
        done_cnt[d] = 0;
        begin_load(d, sq);
        stream(d, n, toggle, pulse_idx);
        g = 0;
        while (done_cnt[d] == 0 && g < 100) begin
            @(posedge clk);
            g++;
        end
        chk("done_seen", done_cnt[d] > 0, 1);
        @(negedge clk);
        chk("busy_after_done", busy[d], 0);
        chk("done_pulse_count", done_cnt[d], 1);
        chk("write_count", wq.size(), quads - sqe);
        chk("accept_count", acc.size(), n);
        for (int w = 0; w < wq.size() && w < quads - sqe; w++) begin
            chk("write_addr", wq[w].a, sqe + w);
            for (int i = 0; i < 4; i++) begin
                k = 4 * (sqe + w) + i;
                chk("write_lane", wq[w].d[i], k < elems ? stim[k - 4 * sqe] : 0);
            end
        end
        k = 4 * (quads - 1) + 1;
        chk("data_hold", qd[d][1], k < elems ? stim[k - 4 * sqe] : 0);
    endtask

    initial begin
        start[0] = 1'b0;
        start[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero(0);
        check_zero(1);
        rst_n = 1'b1;

        // counting stream, valid held high
        run_load(0, 0, 0, 1'b0, -1);
        // extremes then random, valid toggling
        run_load(0, 0, 1, 1'b1, -1);

        // reset after six accepts: outputs clear at once, no write for quad 1
        fill_stim(18, 2);
        wq.delete();
        acc.delete();
        begin_load(0, 0);
        stream(0, 6, 1'b0, -1);
        #2 rst_n = 1'b0;
        #1;
        check_zero(0);
        @(posedge clk); #1 rst_n = 1'b1;
        chk("writes_before_reset", wq.size(), 1);
        if (wq.size() > 0) chk("reset_write_addr", wq[0].a, 0);
        run_load(0, 0, 2, 1'b0, -1);

        // start pulsed mid-load is ignored
        run_load(0, 0, 2, 1'b0, 8);

        // single-matrix configuration
        run_load(1, 0, 0, 1'b0, -1);
        run_load(1, 0, 2, 1'b1, -1);

`ifdef QUAD_LOADER_PARTIAL_START_EN
        run_load(0, 2, 2, 1'b0, -1);
        run_load(0, 7, 2, 1'b1, -1);
        run_load(1, 5, 0, 1'b0, -1);
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
